regfile_op_sequencer: RTL and testbench
=======================================

REGFILE_OP_SEQUENCER -- requirements
Module: regfile_op_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: Clock (input, 1, rising-edge clock) and Reset (input, 1, asynchronous active-high reset).
REQ-002 CmdValid (input, 1) SHALL indicate that a command is offered.
REQ-003 CmdReady (output, 1) SHALL indicate that the sequencer can accept a command.
REQ-004 CmdOp (input, 3) SHALL carry the opcode: 000 LOAD, 001 CLEAR, 010 INC, 011 DEC, 100 MOVE, 101 SWAP, 110/111 reserved.
REQ-005 CmdDst (input, 3) and CmdSrc (input, 3) SHALL carry register indices: 0-3 are R1-R4 and 4-7 are S1-S4.
REQ-006 CmdImm (input, 16) SHALL carry the immediate data for LOAD.
REQ-007 RdSel (input, 3) SHALL be the debug read index.
REQ-008 RfOutA (input, 16) SHALL be the register-file OutA data returned to the sequencer.
REQ-009 The register-file drive outputs SHALL be: RfI (16), RfFunSel (3), RfRegSel (4, active-low enables, bit 3 = R1), RfScrSel (4, active-low enables, bit 3 = S1), RfOutASel (3) and RfOutBSel (3).
REQ-010 Done (output, 1) SHALL be a one-cycle pulse marking command completion.
REQ-011 Err (output, 1) SHALL be a one-cycle pulse, coincident with Done, marking a rejected command.

Function
REQ-012 The register FunSel codes SHALL be: DEC 000, INC 001, LOAD 010, CLEAR 011.
REQ-013 The state machine SHALL have four states: IDLE, STEP1, STEP2 and STEP3.
REQ-014 CmdReady SHALL be 1 only in IDLE.
REQ-015 A command SHALL be accepted at a rising edge where CmdValid and CmdReady are both 1.
- The command fields SHALL be latched at that edge.
- The state SHALL go to STEP1.
REQ-016 CmdValid SHALL be ignored outside IDLE.
REQ-017 In IDLE, the outputs SHALL be: RfRegSel=1111, RfScrSel=1111, RfFunSel=LOAD, RfI=0, RfOutASel=0, Done=0, Err=0.
REQ-018 RfOutBSel SHALL equal RdSel combinationally in every state.
REQ-019 Enable decode SHALL work as follows.
- An index of 0-3 SHALL drive RfRegSel bit (3-idx) low.
- An index of 4-7 SHALL drive RfScrSel bit (7-idx) low.
- At most one enable SHALL be low in any cycle.
REQ-020 LOAD, CLEAR, INC and DEC SHALL be single-step operations.
- In STEP1, the Dst enable SHALL be low with RfFunSel set to the matching code.
- For LOAD, RfI SHALL equal CmdImm.
- Done SHALL be 1 in STEP1, and the next state SHALL be IDLE.
REQ-021 MOVE SHALL be a single-step operation: in STEP1, RfOutASel=Src, RfI=RfOutA, the Dst enable low with RfFunSel=LOAD, and Done=1.
REQ-022 MOVE with Src==Dst SHALL execute normally.
REQ-023 SWAP SHALL use S4 (index 7) as a temporary and take three steps, each with RfFunSel=LOAD and RfI=RfOutA.
- STEP1: RfOutASel=Dst, and the S4 enable SHALL be low.
- STEP2: RfOutASel=Src, and the Dst enable SHALL be low.
- STEP3: RfOutASel=7, the Src enable SHALL be low, and Done SHALL be 1.
REQ-024 SWAP with Src==Dst SHALL complete in STEP1 with no enable low and Done=1.
REQ-025 A reserved opcode, or a SWAP with Src==7 or Dst==7, SHALL be rejected: STEP1 SHALL drive no enable and assert Done=1 and Err=1, and the next state SHALL be IDLE.
REQ-026 Latency from the accept edge to the Done cycle SHALL be 1 cycle for single-step operations and 3 cycles for SWAP.
- The final register write SHALL commit at the edge that ends the Done cycle.
REQ-027 Back-to-back commands SHALL be accepted no earlier than the edge following a Done cycle, which is the first IDLE cycle.
REQ-028 The outputs SHALL be decoded combinationally from the state and the latched command, except RfI, whose path from RfOutA SHALL also be combinational.

Reset
REQ-029 Reset=1 SHALL immediately force IDLE and the latched command to zero, without waiting for a clock edge.
- In consequence, all enables SHALL deassert (1111/1111), and Done=0, Err=0 and CmdReady=1.
REQ-030 Reset asserted mid-SWAP SHALL abort the sequence.
- Writes already committed SHALL remain.
- No further writes SHALL occur, and no Done pulse SHALL be issued.
REQ-031 After Reset deasserts, the first command SHALL be accepted at the first rising edge with CmdValid=1.

Structure
REQ-032 A shared package regfile_pkg SHALL hold the opcode constants, the FunSel constants, the state encoding, and the temporary index value 7.
REQ-033 The block SHALL have one sub-module, regfile_sel_decode, which maps a 3-bit index plus an enable into the {RegSel, ScrSel} active-low pair.
REQ-034 The block SHALL contain no datapath storage other than the latched command and the state register.

Verification
REQ-035 Scenario: LOAD Dst=2 Imm=16'hBEEF -> the STEP1 cycle shows RfRegSel=1101, RfFunSel=010, RfI=BEEF, and Done=1 for one cycle.
REQ-036 Scenario: SWAP Src=0 Dst=5 with a register-file model holding R1=1111 and S2=2222 -> Done arrives 3 cycles after accept, and afterwards R1=2222, S2=1111 and S4=2222.
REQ-037 Scenario: SWAP Src=3 Dst=7, and separately CmdOp=110 -> each produces one cycle with Done=1 and Err=1 and no enable low; the register-file model is unchanged.
REQ-038 Scenario: CmdValid held high continuously with INC Dst=4 -> accepts occur every 2 cycles, and S1 increments once per Done.
REQ-039 Scenario: Reset asserted during the SWAP STEP2 cycle -> the enables go high immediately, no Done is issued, CmdReady=1, and only the STEP1 write has taken effect.
REQ-040 Scenario: RdSel swept 0-7 in every state -> RfOutBSel equals RdSel in each cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared opcode, FunSel and state definitions for the register-file op sequencer.
// The scratch register S4 (index 7) is reserved as the SWAP temporary.
package regfile_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_CLEAR = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_MOVE  = 3'b100;
  localparam logic [2:0] OP_SWAP  = 3'b101;

  localparam logic [2:0] FS_DEC   = 3'b000;
  localparam logic [2:0] FS_INC   = 3'b001;
  localparam logic [2:0] FS_LOAD  = 3'b010;
  localparam logic [2:0] FS_CLEAR = 3'b011;

  localparam logic [2:0] TMP_IDX  = 3'd7;

  typedef enum logic [1:0] {IDLE, STEP1, STEP2, STEP3} state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  dst;
    logic [2:0]  src;
    logic [15:0] imm;
  } cmd_t;

endpackage

// File: rtl/regfile_sel_decode.sv
// Maps a 3-bit register index (0-3 = R1-R4, 4-7 = S1-S4) plus an enable onto
// the active-low {RegSel, ScrSel} enable pair; bit 3 of each selects the first register.
module regfile_sel_decode (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [3:0] regsel,
  output logic [3:0] scrsel
);

  always_comb begin
    regsel = '1;
    scrsel = '1;
    if (en) begin
      if (idx[2]) scrsel[~idx[1:0]] = 1'b0;
      else        regsel[~idx[1:0]] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Command sequencer that drives a register file through LOAD/CLEAR/INC/DEC/MOVE/SWAP,
// using S4 as the temporary for the three-step SWAP.
module regfile_op_sequencer
  import regfile_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [2:0]  CmdOp,
  input  logic [2:0]  CmdDst,
  input  logic [2:0]  CmdSrc,
  input  logic [15:0] CmdImm,
  input  logic [2:0]  RdSel,
  input  logic [15:0] RfOutA,
  output logic [15:0] RfI,
  output logic [2:0]  RfFunSel,
  output logic [3:0]  RfRegSel,
  output logic [3:0]  RfScrSel,
  output logic [2:0]  RfOutASel,
  output logic [2:0]  RfOutBSel,
  output logic        Done,
  output logic        Err
);

  state_t     state, state_nxt;
  cmd_t       cmd;
  logic       sel_en;
  logic [2:0] sel_idx;
  logic       swap_bad, swap_nop;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cmd   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && CmdValid)
        cmd <= '{op: CmdOp, dst: CmdDst, src: CmdSrc, imm: CmdImm};
    end
  end

  // A SWAP touching the temporary would corrupt its own operand, so it is rejected.
  assign swap_bad = (cmd.src == TMP_IDX) || (cmd.dst == TMP_IDX);
  assign swap_nop = (cmd.src == cmd.dst);

  always_comb begin
    state_nxt = state;
    CmdReady  = 1'b0;
    RfI       = '0;
    RfFunSel  = FS_LOAD;
    RfOutASel = '0;
    sel_en    = 1'b0;
    sel_idx   = cmd.dst;
    Done      = 1'b0;
    Err       = 1'b0;
    case (state)
      IDLE: begin
        CmdReady = 1'b1;
        if (CmdValid) state_nxt = STEP1;
      end
      STEP1: begin
        Done      = 1'b1;
        state_nxt = IDLE;
        case (cmd.op)
          OP_LOAD: begin
            sel_en = 1'b1;
            RfI    = cmd.imm;
          end
          OP_CLEAR: begin
            sel_en   = 1'b1;
            RfFunSel = FS_CLEAR;
          end
          OP_INC: begin
            sel_en   = 1'b1;
            RfFunSel = FS_INC;
          end
          OP_DEC: begin
            sel_en   = 1'b1;
            RfFunSel = FS_DEC;
          end
          OP_MOVE: begin
            sel_en    = 1'b1;
            RfOutASel = cmd.src;
            RfI       = RfOutA;
          end
          OP_SWAP: begin
            if (swap_bad) begin
              Err = 1'b1;
            end else if (!swap_nop) begin
              Done      = 1'b0;
              state_nxt = STEP2;
              sel_en    = 1'b1;
              sel_idx   = TMP_IDX;
              RfOutASel = cmd.dst;
              RfI       = RfOutA;
            end
          end
          default: Err = 1'b1;
        endcase
      end
      STEP2: begin
        state_nxt = STEP3;
        sel_en    = 1'b1;
        RfOutASel = cmd.src;
        RfI       = RfOutA;
      end
      STEP3: begin
        state_nxt = IDLE;
        Done      = 1'b1;
        sel_en    = 1'b1;
        sel_idx   = cmd.src;
        RfOutASel = TMP_IDX;
        RfI       = RfOutA;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign RfOutBSel = RdSel;

  regfile_sel_decode u_sel_decode (
    .idx    (sel_idx),
    .en     (sel_en),
    .regsel (RfRegSel),
    .scrsel (RfScrSel)
  );

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Self-checking bench: a register-file model driven by the DUT, checked against a
// command-level reference of what each command must do to the eight registers.
module tb_regfile_op_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        CmdValid = 1'b0;
  logic        CmdReady;
  logic [2:0]  CmdOp = '0, CmdDst = '0, CmdSrc = '0, RdSel = '0;
  logic [15:0] CmdImm = '0;
  logic [15:0] RfOutA, RfI;
  logic [2:0]  RfFunSel, RfOutASel, RfOutBSel;
  logic [3:0]  RfRegSel, RfScrSel;
  logic        Done, Err;

  logic [15:0] rf [8] = '{default: 16'h0};
  logic [15:0] ref_rf [8] = '{default: 16'h0};
  int          ncmp = 0, nerr = 0, done_cnt = 0;

  logic [3:0]  s1_reg, s1_scr;
  logic [2:0]  s1_fun;
  logic [15:0] s1_i;
  logic        s1_done, s1_err;

  regfile_op_sequencer dut (
    .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdDst(CmdDst), .CmdSrc(CmdSrc), .CmdImm(CmdImm),
    .RdSel(RdSel), .RfOutA(RfOutA), .RfI(RfI), .RfFunSel(RfFunSel),
    .RfRegSel(RfRegSel), .RfScrSel(RfScrSel), .RfOutASel(RfOutASel),
    .RfOutBSel(RfOutBSel), .Done(Done), .Err(Err)
  );

  always #5 Clock = ~Clock;

  // Register file: index 0-3 enabled by RegSel[3-i], 4-7 by ScrSel[7-i], active low.
  assign RfOutA = rf[RfOutASel];
  always @(posedge Clock) begin
    for (int i = 0; i < 8; i++) begin
      if (((i < 4) ? RfRegSel[3 - (i % 4)] : RfScrSel[3 - (i % 4)]) == 1'b0) begin
        case (RfFunSel)
          3'b010:  rf[i] <= RfI;
          3'b011:  rf[i] <= 16'h0;
          3'b001:  rf[i] <= rf[i] + 16'd1;
          3'b000:  rf[i] <= rf[i] - 16'd1;
          default: ;
        endcase
      end
    end
  end

  always @(posedge Clock) if (Done === 1'b1) done_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    ncmp++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s reg%0d", tag, i), 32'(rf[i]), 32'(ref_rf[i]));
  endtask

  // Command-level reference: effect on registers, latency and rejection.
  task automatic ref_exec(input logic [2:0] op, d, s, input logic [15:0] imm,
                          output int lat, output logic err);
    logic [15:0] t;
    lat = 1;
    err = (op > 3'd5) || (op == 3'd5 && (s == 3'd7 || d == 3'd7));
    if (!err) begin
      case (op)
        3'd0: ref_rf[d] = imm;
        3'd1: ref_rf[d] = 16'h0;
        3'd2: ref_rf[d] = ref_rf[d] + 16'd1;
        3'd3: ref_rf[d] = ref_rf[d] - 16'd1;
        3'd4: ref_rf[d] = ref_rf[s];
        default: if (s != d) begin
          t = ref_rf[d];
          ref_rf[d] = ref_rf[s];
          ref_rf[s] = t;
          ref_rf[7] = t;
          lat = 3;
        end
      endcase
    end
  endtask

  task automatic run_cmd(input logic [2:0] op, d, s, input logic [15:0] imm, input string tag);
    int lat, wl;
    logic e, we;
    @(negedge Clock);
    CmdValid = 1'b1; CmdOp = op; CmdDst = d; CmdSrc = s; CmdImm = imm;
    @(posedge Clock); #1;
    CmdValid = 1'b0;
    CmdOp = 3'($urandom); CmdDst = 3'($urandom); CmdSrc = 3'($urandom); CmdImm = 16'($urandom);
    s1_reg = RfRegSel; s1_scr = RfScrSel; s1_fun = RfFunSel; s1_i = RfI;
    s1_done = Done; s1_err = Err;
    lat = 0; e = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      if (n > 1) begin @(posedge Clock); #1; end
      if (Done === 1'b1) begin lat = n; e = Err; break; end
    end
    ref_exec(op, d, s, imm, wl, we);
    chk({tag, " latency"}, lat, wl);
    chk({tag, " err"}, 32'(e), 32'(we));
    if (lat != 0) begin
      @(posedge Clock); #1;
      chk({tag, " done pulse"}, 32'(Done), 0);
      chk({tag, " ready"}, 32'(CmdReady), 1);
    end
    chk_regs(tag);
  endtask

  typedef struct {
    logic [2:0]  op, d, s;
    logic [15:0] imm;
    logic [3:0]  regsel, scrsel;
    logic        chk_f;
    logic [2:0]  fun;
    logic        chk_i;
    logic [15:0] i;
    logic        err;
  } vec_t;

  // RdSel walks through 0-7 continuously so every state sees every value.
  initial begin
    forever begin
      @(negedge Clock);
      RdSel = RdSel + 3'd1;
      #1;
      chk("outbsel", 32'(RfOutBSel), 32'(RdSel));
      chk("one enable", 32'($countones({RfRegSel, RfScrSel}) >= 7), 1);
    end
  end

  initial begin
    vec_t vecs [10];
    int acc, dn, base;
    vecs[0] = '{3'd0, 3'd2, 3'd0, 16'hBEEF, 4'b1101, 4'b1111, 1'b1, 3'b010, 1'b1, 16'hBEEF, 1'b0};
    vecs[1] = '{3'd1, 3'd0, 3'd0, 16'h0,    4'b0111, 4'b1111, 1'b1, 3'b011, 1'b0, 16'h0,    1'b0};
    vecs[2] = '{3'd2, 3'd4, 3'd1, 16'h0,    4'b1111, 4'b0111, 1'b1, 3'b001, 1'b0, 16'h0,    1'b0};
    vecs[3] = '{3'd3, 3'd6, 3'd2, 16'h0,    4'b1111, 4'b1101, 1'b1, 3'b000, 1'b0, 16'h0,    1'b0};
    vecs[4] = '{3'd0, 3'd7, 3'd0, 16'h1234, 4'b1111, 4'b1110, 1'b1, 3'b010, 1'b1, 16'h1234, 1'b0};
    vecs[5] = '{3'd6, 3'd1, 3'd2, 16'h5555, 4'b1111, 4'b1111, 1'b0, 3'b000, 1'b0, 16'h0,    1'b1};
    vecs[6] = '{3'd7, 3'd3, 3'd0, 16'h0,    4'b1111, 4'b1111, 1'b0, 3'b000, 1'b0, 16'h0,    1'b1};
    vecs[7] = '{3'd5, 3'd7, 3'd3, 16'h0,    4'b1111, 4'b1111, 1'b0, 3'b000, 1'b0, 16'h0,    1'b1};
    vecs[8] = '{3'd5, 3'd0, 3'd7, 16'h0,    4'b1111, 4'b1111, 1'b0, 3'b000, 1'b0, 16'h0,    1'b1};
    vecs[9] = '{3'd2, 3'd3, 3'd0, 16'h0,    4'b1110, 4'b1111, 1'b1, 3'b001, 1'b0, 16'h0,    1'b0};

    #1;
    chk("rst ready", 32'(CmdReady), 1);
    chk("rst regsel", 32'(RfRegSel), 32'hF);
    chk("rst scrsel", 32'(RfScrSel), 32'hF);
    chk("rst done/err", 32'({Done, Err}), 0);
    chk("rst funsel", 32'(RfFunSel), 32'h2);
    chk("rst rfi/outa", 32'({RfI, RfOutASel}), 0);
    @(negedge Clock);
    Reset = 1'b0;

    for (int k = 0; k < 10; k++) begin
      run_cmd(vecs[k].op, vecs[k].d, vecs[k].s, vecs[k].imm, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d regsel", k), 32'(s1_reg), 32'(vecs[k].regsel));
      chk($sformatf("vec%0d scrsel", k), 32'(s1_scr), 32'(vecs[k].scrsel));
      chk($sformatf("vec%0d s1 done/err", k), 32'({s1_done, s1_err}), 32'({1'b1, vecs[k].err}));
      if (vecs[k].chk_f) chk($sformatf("vec%0d funsel", k), 32'(s1_fun), 32'(vecs[k].fun));
      if (vecs[k].chk_i) chk($sformatf("vec%0d rfi", k), 32'(s1_i), 32'(vecs[k].i));
    end

    // SWAP R1 <-> S2 through S4
    run_cmd(3'd0, 3'd0, 3'd0, 16'h1111, "ld r1");
    run_cmd(3'd0, 3'd5, 3'd0, 16'h2222, "ld s2");
    run_cmd(3'd5, 3'd5, 3'd0, 16'h0, "swap");
    chk("swap s1 scrsel", 32'(s1_scr), 32'hE);
    chk("swap r1", 32'(rf[0]), 32'h2222);
    chk("swap s2", 32'(rf[5]), 32'h1111);
    chk("swap s4", 32'(rf[7]), 32'h2222);
    run_cmd(3'd5, 3'd2, 3'd2, 16'h0, "swap same");
    chk("swap same enables", 32'({s1_reg, s1_scr}), 32'hFF);
    run_cmd(3'd4, 3'd1, 3'd1, 16'h0, "move same");
    run_cmd(3'd4, 3'd6, 3'd5, 16'h0, "move");

    // CmdValid held high with INC S1
    acc = 0; dn = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clock);
      if (k == 0) begin CmdValid = 1'b1; CmdOp = 3'd2; CmdDst = 3'd4; CmdSrc = 3'd0; end
      if (CmdReady) begin acc++; chk("b2b accept phase", 32'(k % 2), 0); end
      if (Done) dn++;
    end
    @(negedge Clock);
    CmdValid = 1'b0;
    @(posedge Clock); #1;
    ref_rf[4] = ref_rf[4] + 16'd4;
    chk("b2b accepts", acc, 4);
    chk("b2b dones", dn, 4);
    chk_regs("b2b");

    // Reset during SWAP STEP2
    run_cmd(3'd0, 3'd1, 3'd0, 16'hAAAA, "ld r2");
    run_cmd(3'd0, 3'd2, 3'd0, 16'h5555, "ld r3");
    run_cmd(3'd0, 3'd7, 3'd0, 16'h7777, "ld s4");
    base = done_cnt;
    @(negedge Clock);
    CmdValid = 1'b1; CmdOp = 3'd5; CmdDst = 3'd2; CmdSrc = 3'd1;
    @(posedge Clock); #1;
    CmdValid = 1'b0;
    @(posedge Clock); #2;
    Reset = 1'b1;
    #1;
    chk("abort enables", 32'({RfRegSel, RfScrSel}), 32'hFF);
    chk("abort ready", 32'(CmdReady), 1);
    chk("abort done", 32'({Done, Err}), 0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock); #1;
    ref_rf[7] = ref_rf[2];
    chk("abort no done", done_cnt, base);
    chk_regs("abort");
    run_cmd(3'd3, 3'd1, 3'd0, 16'h0, "post reset");

    for (int k = 0; k < 40; k++)
      run_cmd(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 16'($urandom),
              $sformatf("rnd%0d", k));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
